factor_check_seq: RTL and testbench

FACTOR_CHECK_SEQ -- requirements
Module: factor_check_seq

---
 rtl/factor_check_seq_if.sv | 25 ++
 rtl/factor_check_seq.sv | 128 ++++++++++++
 tb/tb_factor_check_seq.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/factor_check_seq_if.sv
// Handshake and data bundle for factor_check_seq: operands in; status and registered results out.
interface factor_check_seq_if #(
  parameter int unsigned W = 4
) ();
  logic           start;
  logic [W-1:0]   i1;
  logic [W-1:0]   i2;
  logic [2*W-1:0] a;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           match;
  logic           nontriv;
  logic           o_1;

  modport master (
    output start, i1, i2, a,
    input  busy, done, product, match, nontriv, o_1
  );

  modport slave (
    input  start, i1, i2, a,
    output busy, done, product, match, nontriv, o_1
  );
endinterface

// File: rtl/factor_check_seq.sv
// Sequential shift-add multiplier checking whether i1*i2 equals a target, optionally
// requiring both factors to be non-trivial (> 1). One result per W+1 cycles.
module factor_check_seq #(
  parameter int unsigned W             = 4,
  parameter bit          CHECK_NONTRIV = 1'b1
) (
  input logic               clk,
  input logic               rst,
  factor_check_seq_if.slave bus
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         r_state;
  state_e         w_state_next;
  logic           w_accept;
  logic           w_last;

  logic [W-1:0]   r_i1;
  logic [W-1:0]   r_i2;
  logic [2*W-1:0] r_a;
  logic [2*W-1:0] r_acc;
  logic [CntW-1:0] r_cnt;

  logic [2*W-1:0] w_addend;
  logic [2*W-1:0] w_acc_next;
  logic           w_match;
  logic           w_nontriv;
  logic           w_o1;

  logic [2*W-1:0] r_product;
  logic           r_match;
  logic           r_nontriv;
  logic           r_o1;

  assign w_last = (r_cnt == CntW'(W - 1));

  // One partial product per cycle; r_i2 is the multiplier, r_i1 the multiplicand.
  always_comb begin
    w_addend = '0;
    if (r_i2[r_cnt]) begin
      w_addend = {{W{1'b0}}, r_i1} << r_cnt;
    end
    w_acc_next = r_acc + w_addend;
    w_match    = (w_acc_next == r_a);
    w_nontriv  = (r_i1 > W'(1)) && (r_i2 > W'(1));
    w_o1       = CHECK_NONTRIV ? (w_match && w_nontriv) : w_match;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = StRun;
        end else begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_a   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_i1  <= bus.i1;
      r_i2  <= bus.i2;
      r_a   <= bus.a;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == StRun) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  // Results only change on the last RUN step, so they hold across a new start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_product <= '0;
      r_match   <= 1'b0;
      r_nontriv <= 1'b0;
      r_o1      <= 1'b0;
    end else if ((r_state == StRun) && w_last) begin
      r_product <= w_acc_next;
      r_match   <= w_match;
      r_nontriv <= w_nontriv;
      r_o1      <= w_o1;
    end
  end

  assign bus.busy    = (r_state == StRun);
  assign bus.done    = (r_state == StDone);
  assign bus.product = r_product;
  assign bus.match   = r_match;
  assign bus.nontriv = r_nontriv;
  assign bus.o_1     = r_o1;

endmodule

// File: tb/tb_factor_check_seq.sv
// Scoreboard bench for factor_check_seq: W=4 (both CHECK_NONTRIV settings) and W=8.
module tb_factor_check_seq;

  localparam int unsigned W4 = 4;
  localparam int unsigned W8 = 8;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  factor_check_seq_if #(.W(W4)) b4 ();
  factor_check_seq_if #(.W(W4)) b4n ();
  factor_check_seq_if #(.W(W8)) b8 ();

  assign b4n.start = b4.start;
  assign b4n.i1    = b4.i1;
  assign b4n.i2    = b4.i2;
  assign b4n.a     = b4.a;

  factor_check_seq #(.W(W4), .CHECK_NONTRIV(1'b1)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
  factor_check_seq #(.W(W4), .CHECK_NONTRIV(1'b0)) u_dut4n (.clk(clk), .rst(rst), .bus(b4n));
  factor_check_seq #(.W(W8), .CHECK_NONTRIV(1'b1)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));

  typedef struct {
    int prod;
    int mat;
    int nt;
    int o1;
    int acc;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int   free4;
  int   free8;
  int   busy4;
  int   busy8;
  int   last4;
  int   last8;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int x, input int y, input int z, input int e);
    exp_t r;
    r.prod = x * y;
    r.mat  = (r.prod == z) ? 1 : 0;
    r.nt   = (x > 1 && y > 1) ? 1 : 0;
    r.o1   = r.mat & r.nt;
    r.acc  = e;
    return r;
  endfunction

  task automatic issue4(input int x, input int y, input int z);
    @(negedge clk);
    b4.i1    = 4'(x);
    b4.i2    = 4'(y);
    b4.a     = 8'(z);
    b4.start = 1'b1;
    @(posedge clk);
    #1;
    if (!rst && cyc >= free4) begin
      q4.push_back(model(x, y, z, cyc));
      free4 = cyc + W4 + 1;
    end
    b4.start = 1'b0;
  endtask

  task automatic issue8(input int x, input int y, input int z);
    @(negedge clk);
    b8.i1    = 8'(x);
    b8.i2    = 8'(y);
    b8.a     = 16'(z);
    b8.start = 1'b1;
    @(posedge clk);
    #1;
    if (!rst && cyc >= free8) begin
      q8.push_back(model(x, y, z, cyc));
      free8 = cyc + W8 + 1;
    end
    b8.start = 1'b0;
  endtask

  task automatic check_zero4(input string tag);
    chk({tag, "_busy"}, int'(b4.busy), 0);
    chk({tag, "_done"}, int'(b4.done), 0);
    chk({tag, "_product"}, int'(b4.product), 0);
    chk({tag, "_match"}, int'(b4.match), 0);
    chk({tag, "_nontriv"}, int'(b4.nontriv), 0);
    chk({tag, "_o1"}, int'(b4.o_1), 0);
    chk({tag, "_o1_nc"}, int'(b4n.o_1), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy4 = 0;
      last4 = 0;
    end else begin
      if (b4.busy) busy4++;
      if (b4.done) begin
        if (q4.size() == 0) begin
          chk("spurious_done4", int'(b4.done), 0);
        end else begin
          e = q4.pop_front();
          chk("latency4", cyc - e.acc, W4);
          chk("busy_cycles4", busy4, W4);
          chk("product4", int'(b4.product), e.prod);
          chk("match4", int'(b4.match), e.mat);
          chk("nontriv4", int'(b4.nontriv), e.nt);
          chk("o1_4", int'(b4.o_1), e.o1);
          chk("done4_nc", int'(b4n.done), 1);
          chk("o1_4_nc", int'(b4n.o_1), e.mat);
          last4 = e.prod;
        end
        busy4 = 0;
      end else begin
        chk("hold4", int'(b4.product), last4);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy8 = 0;
      last8 = 0;
    end else begin
      if (b8.busy) busy8++;
      if (b8.done) begin
        if (q8.size() == 0) begin
          chk("spurious_done8", int'(b8.done), 0);
        end else begin
          e = q8.pop_front();
          chk("latency8", cyc - e.acc, W8);
          chk("busy_cycles8", busy8, W8);
          chk("product8", int'(b8.product), e.prod);
          chk("match8", int'(b8.match), e.mat);
          chk("nontriv8", int'(b8.nontriv), e.nt);
          chk("o1_8", int'(b8.o_1), e.o1);
          last8 = e.prod;
        end
        busy8 = 0;
      end else begin
        chk("hold8", int'(b8.product), last8);
      end
    end
  end

  initial begin
    int x;
    int y;
    int z;
    int sel;
    rst      = 1'b1;
    b4.start = 1'b0;
    b4.i1    = '0;
    b4.i2    = '0;
    b4.a     = '0;
    b8.start = 1'b0;
    b8.i1    = '0;
    b8.i2    = '0;
    b8.a     = '0;
    free4    = 0;
    free8    = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero4("reset");
    chk("reset_busy8", int'(b8.busy), 0);
    chk("reset_done8", int'(b8.done), 0);
    @(negedge clk);
    rst = 1'b0;

    issue4(3, 5, 15);
    repeat (8) @(posedge clk);
    issue4(1, 15, 15);
    repeat (8) @(posedge clk);
    // Second start lands in the DONE cycle of the first.
    issue4(4, 4, 17);
    repeat (W4) @(posedge clk);
    issue4(15, 15, 225);
    repeat (8) @(posedge clk);
    issue4(3, 5, 15);
    @(posedge clk);
    issue4(2, 2, 4);
    repeat (8) @(posedge clk);

    issue4(9, 7, 63);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero4("midrun_reset");
    q4.delete();
    free4 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue4(6, 2, 12);
    repeat (8) @(posedge clk);

    for (int i = 0; i < 150; i++) begin
      x   = $urandom_range(0, 15);
      y   = $urandom_range(0, 15);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       z = x * y;
        1:       z = $urandom_range(0, 255);
        2:       z = (x * y + 1) % 256;
        default: z = $urandom_range(226, 255);
      endcase
      issue4(x, y, z);
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end

    issue8(255, 255, 65025);
    repeat (12) @(posedge clk);
    issue8(0, 77, 0);
    repeat (12) @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      x   = $urandom_range(0, 255);
      y   = $urandom_range(0, 255);
      sel = $urandom_range(0, 2);
      case (sel)
        0:       z = x * y;
        1:       z = $urandom_range(0, 65535);
        default: z = $urandom_range(65026, 65535);
      endcase
      issue8(x, y, z);
      repeat ($urandom_range(0, 10)) @(posedge clk);
    end

    for (int i = 0; i < 40 && (q4.size() != 0 || q8.size() != 0); i++) @(posedge clk);
    #1;
    chk("pending4", q4.size(), 0);
    chk("pending8", q8.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
